// File: rtl/fifo_uart_tx_if.sv
// FIFO read port between the output FIFO and its UART drain.
// master = drain side (issues pops), slave = FIFO side (supplies data/empty).
interface fifo_uart_tx_if;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_data,
    input  fifo_empty
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_data,
    output fifo_empty
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops 32-bit words from a registered-read FIFO and sends WORD_BYTES
// 8N1 UART frames per word, least-significant byte first.
module fifo_uart_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [1:0]  BYTE_LAST = 2'(WORD_BYTES - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] shreg;
  logic        bit_end;
  logic        last_byte;
  logic        pop;

  always_comb begin
    bit_end   = (baud_cnt == BAUD_LAST);
    last_byte = (byte_cnt == BYTE_LAST);
    pop       = reset && (state == IDLE) && enable && !fifo.fifo_empty;
    state_nx  = state;
    tx        = 1'b1;
    unique case (state)
      IDLE:  if (pop) state_nx = WAIT;
      WAIT:  state_nx = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_end && (bit_cnt == 3'd7)) state_nx = STOP;
      end
      STOP:  if (bit_end) state_nx = last_byte ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end

  assign fifo.fifo_rd_en = pop;
  assign busy            = (state != IDLE);
  assign word_done       = (state == STOP) && bit_end && last_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Shifting by one per data bit leaves the next byte in [7:0] after each frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
    end else begin
      unique case (state)
        IDLE: baud_cnt <= '0;
        WAIT: begin
          shreg    <= fifo.fifo_data;
          byte_cnt <= '0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            bit_cnt  <= bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!last_byte) byte_cnt <= byte_cnt + 2'd1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: baud_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: CLK_DIV=4/WORD_BYTES=4 instance with a FIFO model and a
// per-cycle line trace, plus a CLK_DIV=1/WORD_BYTES=1 instance checked bit by bit.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic en1;
  logic tx4, busy4, wd4;
  logic tx1, busy1, wd1;

  always #5 clk = ~clk;

  fifo_uart_tx_if f4();
  fifo_uart_tx_if f1();

  fifo_uart_tx #(.CLK_DIV(4), .WORD_BYTES(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .fifo(f4.master),
    .tx(tx4), .busy(busy4), .word_done(wd4)
  );

  fifo_uart_tx #(.CLK_DIV(1), .WORD_BYTES(1)) u1 (
    .clk(clk), .reset(reset), .enable(en1), .fifo(f1.master),
    .tx(tx1), .busy(busy1), .word_done(wd1)
  );

  // FIFO model with one-cycle registered read
  logic [31:0] fmem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign f4.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (f4.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      f4.fifo_data <= fmem[rd_ptr % 16];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // per-cycle trace of the CLK_DIV=4 instance, sampled mid-cycle
  localparam int LOGN = 4096;
  int   cyc = 0;
  logic tx_log   [0:LOGN-1];
  logic rd_log   [0:LOGN-1];
  logic busy_log [0:LOGN-1];
  logic wd_log   [0:LOGN-1];
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]   <= tx4;
      rd_log[cyc]   <= f4.fifo_rd_en;
      busy_log[cyc] <= busy4;
      wd_log[cyc]   <= wd4;
    end
    cyc <= cyc + 1;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [31:0] w);
    fmem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  function automatic logic tx_at(input int i);
    if (i < 0 || i >= LOGN) return 1'bx;
    return tx_log[i];
  endfunction

  // sel: 0 pop, 1 busy, 2 word_done, 3 tx low
  function automatic logic hit(input int sel, input int i);
    if (i < 0 || i >= LOGN) return 1'b0;
    case (sel)
      0: return rd_log[i] === 1'b1;
      1: return busy_log[i] === 1'b1;
      2: return wd_log[i] === 1'b1;
      default: return tx_log[i] === 1'b0;
    endcase
  endfunction

  function automatic int count(input int sel, input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (hit(sel, i)) n++;
    return n;
  endfunction

  function automatic int first_idx(input int sel, input int from, input int to);
    for (int i = from; i < to; i++) if (hit(sel, i)) return i;
    return -1;
  endfunction

  function automatic int last_idx(input int sel, input int from, input int to);
    int r = -1;
    for (int i = from; i < to; i++) if (hit(sel, i)) r = i;
    return r;
  endfunction

  function automatic int find_start(input int from, input int to);
    for (int i = (from < 1 ? 1 : from); i < to; i++)
      if (tx_at(i) === 1'b0 && tx_at(i - 1) === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic [7:0] dec_byte(input int s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = tx_at(s + 4 * (k + 1) + 2);
    return b;
  endfunction

  task automatic check_word(input string tag, input int s, input logic [31:0] w);
    logic [31:0] wv;
    wv = w;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_start"}, 32'(tx_at(s + 40 * k + 2)), 32'd0);
      check({tag, "_byte"}, 32'(dec_byte(s + 40 * k)), 32'(wv[8*k +: 8]));
      check({tag, "_stop"}, 32'(tx_at(s + 40 * k + 38)), 32'd1);
    end
  endtask

  int m, p, s, s4;
  logic [9:0] frame;

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    en1 = 1'b1;
    f1.fifo_empty = 1'b1;
    f1.fifo_data = 32'hAABB_CCC3;
    push(32'h4433_2211);

    // reset held with a non-empty FIFO and enable high
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_tx", 32'(tx4), 32'd1);
      check("rst_busy", 32'(busy4), 32'd0);
      check("rst_rd_en", 32'(f4.fifo_rd_en), 32'd0);
      check("rst_word_done", 32'(wd4), 32'd0);
    end

    // single word 0x44332211
    reset = 1'b1;
    m = cyc;
    run(200);
    check("w1_pops", 32'(count(0, m, m + 200)), 32'd1);
    p = first_idx(0, m, m + 200);
    check("w1_wait_tx", 32'(tx_at(p + 1)), 32'd1);
    s = find_start(m, m + 200);
    check("w1_start_lat", 32'(s), 32'(p + 2));
    check_word("w1", s, 32'h4433_2211);
    check("w1_busy_len", 32'(count(1, m, m + 200)), 32'd161);
    check("w1_wd_count", 32'(count(2, m, m + 200)), 32'd1);
    check("w1_wd_last_busy", 32'(first_idx(2, m, m + 200)), 32'(last_idx(1, m, m + 200)));
    check("w1_wd_cycle", 32'(first_idx(2, m, m + 200)), 32'(p + 161));

    // two queued words, back to back
    push(32'hA5A5_A5A5);
    push(32'h0000_FF00);
    m = cyc;
    run(360);
    check("w2_pops", 32'(count(0, m, m + 360)), 32'd2);
    s = find_start(m, m + 360);
    check_word("w2a", s, 32'hA5A5_A5A5);
    s4 = find_start(s + 160, m + 360);
    check("w2_gap", 32'(s4 - (s + 160)), 32'd2);
    check("w2_gap_hi0", 32'(tx_at(s + 160)), 32'd1);
    check("w2_gap_hi1", 32'(tx_at(s + 161)), 32'd1);
    check_word("w2b", s4, 32'h0000_FF00);

    // enable low holds off the pop
    enable = 1'b0;
    push(32'h1234_5678);
    push(32'h4433_2211);
    push(32'h0000_0055);
    m = cyc;
    run(20);
    check("en_lo_pops", 32'(count(0, m, m + 20)), 32'd0);
    check("en_lo_tx_low", 32'(count(3, m, m + 20)), 32'd0);
    enable = 1'b1;
    #1;
    check("en_hi_pop_now", 32'(f4.fifo_rd_en), 32'd1);
    m = cyc;
    run(10);
    enable = 1'b0;
    run(190);
    check("en_drop_pops", 32'(count(0, m, m + 200)), 32'd1);
    s = find_start(m, m + 200);
    check_word("en", s, 32'h1234_5678);
    check("en_drop_wd", 32'(count(2, m, m + 200)), 32'd1);
    check("en_drop_idle", 32'(busy4), 32'd0);

    // reset mid-byte 2 of 0x44332211, then 0x55 goes out from byte 0
    enable = 1'b1;
    #1;
    check("mr_pop", 32'(f4.fifo_rd_en), 32'd1);
    run(46);
    check("mr_pre_busy", 32'(busy4), 32'd1);
    check("mr_pre_tx", 32'(tx4), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mr_tx", 32'(tx4), 32'd1);
    check("mr_busy", 32'(busy4), 32'd0);
    check("mr_rd_en", 32'(f4.fifo_rd_en), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    m = cyc;
    run(200);
    check("mr_pops", 32'(count(0, m, m + 200)), 32'd1);
    s = find_start(m, m + 200);
    check_word("mr", s, 32'h0000_0055);
    check("mr_busy_len", 32'(count(1, m, m + 200)), 32'd161);

    // CLK_DIV=1, WORD_BYTES=1: one frame of 0xC3, upper bytes dropped
    frame = {1'b1, 8'hC3, 1'b0};
    f1.fifo_empty = 1'b0;
    #1;
    check("d1_pop", 32'(f1.fifo_rd_en), 32'd1);
    check("d1_idle_busy", 32'(busy1), 32'd0);
    tick();
    f1.fifo_empty = 1'b1;
    check("d1_wait_busy", 32'(busy1), 32'd1);
    check("d1_wait_tx", 32'(tx1), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("d1_bit", 32'(tx1), 32'(frame[k]));
      check("d1_busy", 32'(busy1), 32'd1);
      check("d1_wd", 32'(wd1), (k == 9) ? 32'd1 : 32'd0);
    end
    tick();
    check("d1_end_busy", 32'(busy1), 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("d1_no_upper", 32'({busy1, tx1}), 32'd1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
